// File: rtl/result_gate_arb.sv
// Result-path arbiter: NCH channels onto one registered valid/ready output.
// Fixed-priority or round-robin grant; output forced to zero when not valid.
module result_gate_arb #(
  parameter  int WIDTH = 16,
  parameter  int NCH   = 4,
  parameter  int MODE  = 0,
  localparam int CW    = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 gate_en,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        out_ch,
  output logic [15:0]          xfer_cnt
);

  logic [WIDTH-1:0] ch_data [NCH];
  logic [CW-1:0]    rr_ptr;
  logic [CW-1:0]    winner;
  logic             found;
  logic             accept;
  logic             load;
  int               idx;

  for (genvar i = 0; i < NCH; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  // Search starts at 0 (fixed priority) or at rr_ptr (round robin), wrapping.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (MODE == 0) ? k : (int'(rr_ptr) + k) % NCH;
      if (!found && in_valid[idx]) begin
        found  = 1'b1;
        winner = CW'(idx);
      end
    end
  end

  assign accept   = out_valid & out_ready;
  assign load     = rst_n & gate_en & found & (~out_valid | out_ready);
  assign in_ready = load ? (NCH'(1) << winner) : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      xfer_cnt  <= '0;
      rr_ptr    <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= ch_data[winner];
        out_ch    <= winner;
      end else if (accept) begin
        out_valid <= 1'b0;
        out_data  <= '0;
      end

      if (accept && xfer_cnt != 16'hFFFF) xfer_cnt <= xfer_cnt + 16'd1;

      if (MODE == 1 && load) begin
        rr_ptr <= (winner == CW'(NCH - 1)) ? '0 : winner + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_result_gate_arb.sv
// Bench for result_gate_arb: fixed-priority and round-robin instances share
// stimulus and are each compared against a transaction-level model.
module tb_result_gate_arb;
  localparam int NCH = 4;
  localparam int W   = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               gate_en;
  logic [NCH*W-1:0]   in_data;
  logic [NCH-1:0]     in_valid;
  logic               out_ready;
  logic [1:0][NCH-1:0] rdy;
  logic [1:0][W-1:0]  od;
  logic [1:0]         ov;
  logic [1:0][1:0]    och;
  logic [1:0][15:0]   cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cur_m    = 0;

  // Model state, one slot per instance (0 = fixed priority, 1 = round robin).
  bit mv   [2];
  int md   [2];
  int mc   [2];
  int mcnt [2];
  int mptr [2];
  int obs_grant [2];

  always #5 clk = ~clk;

  result_gate_arb #(.WIDTH(W), .NCH(NCH), .MODE(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .gate_en(gate_en), .in_data(in_data),
    .in_valid(in_valid), .in_ready(rdy[0]), .out_data(od[0]),
    .out_valid(ov[0]), .out_ready(out_ready), .out_ch(och[0]), .xfer_cnt(cnt[0])
  );

  result_gate_arb #(.WIDTH(W), .NCH(NCH), .MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .gate_en(gate_en), .in_data(in_data),
    .in_valid(in_valid), .in_ready(rdy[1]), .out_data(od[1]),
    .out_valid(ov[1]), .out_ready(out_ready), .out_ch(och[1]), .xfer_cnt(cnt[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s mode%0d t=%0t got=%h expected=%h", tag, cur_m, $time, obs, exp);
    end
  endtask

  function automatic int pick(int m);
    for (int k = 0; k < NCH; k++) begin
      int c = (m == 0) ? k : (mptr[m] + k) % NCH;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic int data_of(int ch);
    return int'(in_data[ch*W +: W]);
  endfunction

  // One clock: compare both instances at the falling edge, then advance model.
  task automatic step();
    int g;
    bit ld;
    logic [NCH-1:0] er;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      cur_m = m;
      g  = pick(m);
      ld = rst_n && gate_en && (g >= 0) && (!mv[m] || out_ready);
      er = '0;
      if (ld) er[g] = 1'b1;
      obs_grant[m] = -1;
      for (int i = 0; i < NCH; i++) if (rdy[m][i]) obs_grant[m] = i;
      check("in_ready", 32'(rdy[m]), 32'(er));
      check("out_valid", 32'(ov[m]), 32'(mv[m]));
      check("out_data", 32'(od[m]), md[m]);
      check("out_ch", 32'(och[m]), mc[m]);
      check("xfer_cnt", 32'(cnt[m]), mcnt[m]);
      if (!rst_n) begin
        mv[m] = 0; md[m] = 0; mc[m] = 0; mcnt[m] = 0; mptr[m] = 0;
      end else begin
        if (mv[m] && out_ready && mcnt[m] < 65535) mcnt[m]++;
        if (ld) begin
          mv[m] = 1; md[m] = data_of(g); mc[m] = g;
          if (m == 1) mptr[m] = (g + 1) % NCH;
        end else if (mv[m] && out_ready) begin
          mv[m] = 0; md[m] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_plan_data();
    for (int i = 0; i < NCH; i++) in_data[i*W +: W] = 16'h0A00 + 16'(i);
  endtask

  initial begin
    int exp_rr [5];
    int exp_alt [4];
    exp_rr  = '{0, 1, 2, 3, 0};
    exp_alt = '{3, 0, 3, 0};
    for (int m = 0; m < 2; m++) begin
      mv[m] = 0; md[m] = 0; mc[m] = 0; mcnt[m] = 0; mptr[m] = 0;
    end
    rst_n = 1'b0; gate_en = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Idle after reset.
    gate_en = 1'b1;
    repeat (10) step();

    // All channels valid, downstream always ready.
    set_plan_data();
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      cur_m = 0; check("fp_grant", 32'(obs_grant[0]), 32'd0);
      cur_m = 1; check("rr_grant", 32'(obs_grant[1]), 32'(exp_rr[k]));
    end
    cur_m = 0; check("fp_data", 32'(od[0]), 32'h0A00);
    in_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      step();
      cur_m = 1; check("rr_alt", 32'(obs_grant[1]), 32'(exp_alt[k]));
    end

    // Backpressure on a single word from channel 2.
    do_reset();
    in_data[2*W +: W] = 16'hBEEF;
    in_valid  = 4'b0100;
    out_ready = 1'b0;
    step();
    in_valid = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      cur_m = 0;
      check("bp_data", 32'(od[0]), 32'hBEEF);
      check("bp_ch", 32'(och[0]), 32'd2);
      check("bp_rdy", 32'(rdy[0]), 32'd0);
    end
    out_ready = 1'b1;
    step();
    step();
    cur_m = 0; check("bp_zero", 32'(od[0]), 32'd0);

    // Gate low with all channels valid.
    gate_en = 1'b0;
    set_plan_data();
    in_valid = 4'b1111;
    repeat (4) step();
    cur_m = 0; check("gate_off", 32'(ov[0]), 32'd0);

    // Gate falls while a word is held: the word still completes.
    gate_en = 1'b1; out_ready = 1'b0;
    step();
    gate_en = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    repeat (3) step();

    // Reset while holding discards the word.
    gate_en = 1'b1; out_ready = 1'b0;
    step();
    in_valid = '0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    cur_m = 1; check("rst_drop", 32'(ov[1]), 32'd0);

    // Randomised traffic.
    for (int k = 0; k < 600; k++) begin
      in_valid  = NCH'($urandom_range(0, (1 << NCH) - 1));
      for (int i = 0; i < NCH; i++) in_data[i*W +: W] = W'($urandom);
      gate_en   = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 63) != 0);
      step();
    end

    // Counter saturation.
    rst_n = 1'b1;
    do_reset();
    gate_en = 1'b1; out_ready = 1'b1; in_valid = 4'b1111;
    set_plan_data();
    repeat (65545) step();
    cur_m = 0; check("sat_fp", 32'(cnt[0]), 32'hFFFF);
    cur_m = 1; check("sat_rr", 32'(cnt[1]), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
